// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the execute stage (slot 0) and the aux unit (slot 1).
// Latency: operands on the ALU one edge after the grant, result captured WAIT_CYCLES later, done pulses the cycle after.
package alu_pkg;
    typedef enum logic [3:0] {
        ALU_SLL  = 4'b0000,
        ALU_SRL  = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0011,
        ALU_AND  = 4'b0100,
        ALU_OR   = 4'b0101,
        ALU_XOR  = 4'b0110,
        ALU_NOR  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } aluop_t;
endpackage

module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        req0,
    input  logic        req1,
    input  aluop_t      op0,
    input  aluop_t      op1,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    output logic        done0,
    output logic        done1,
    output logic        busy,
    output logic        grant,
    output logic [31:0] result,
    output logic        res_neg,
    output logic        res_ovf,
    output logic        res_zero,
    output aluop_t      alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_out,
    input  logic        alu_neg,
    input  logic        alu_ovf,
    input  logic        alu_zero
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       last;
    logic       start;
    logic       win;

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        win       = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    start     = 1'b1;
                    // On a tie the slot that was not served last goes next.
                    win       = (req0 && req1) ? ~last : req1;
                    state_nxt = EXEC;
                end
            end
            EXEC:    if (cnt == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt      <= 4'd0;
            last     <= 1'b1;
            grant    <= 1'b0;
            alu_op   <= aluop_t'(4'b0000);
            alu_a    <= 32'd0;
            alu_b    <= 32'd0;
            result   <= 32'd0;
            res_neg  <= 1'b0;
            res_ovf  <= 1'b0;
            res_zero <= 1'b0;
        end else begin
            if (start) begin
                grant  <= win;
                alu_op <= win ? op1 : op0;
                alu_a  <= win ? a1 : a0;
                alu_b  <= win ? b1 : b0;
                cnt    <= CNT_INIT;
            end
            if (state == EXEC) begin
                if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    result   <= alu_out;
                    res_neg  <= alu_neg;
                    res_ovf  <= alu_ovf;
                    res_zero <= alu_zero;
                end
            end
            if (state == DONE) last <= grant;
        end
    end

    assign busy  = (state != IDLE);
    assign done0 = (state == DONE) && !grant;
    assign done1 = (state == DONE) &&  grant;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU behind two instances (WAIT_CYCLES = 1 and 3).
module tb_alu_arbiter;
    import alu_pkg::*;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    function automatic logic [34:0] alu_f(input aluop_t op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] o;
        logic        v;
        o = 32'd0;
        v = 1'b0;
        case (op)
            ALU_SLL: o = a << b[4:0];
            ALU_SRL: o = a >> b[4:0];
            ALU_ADD: begin o = a + b; v = (a[31] == b[31]) && (o[31] != a[31]); end
            ALU_SUB: begin o = a - b; v = (a[31] != b[31]) && (o[31] != a[31]); end
            ALU_AND: o = a & b;
            ALU_OR:  o = a | b;
            ALU_XOR: o = a ^ b;
            ALU_NOR: o = ~(a | b);
            default: o = 32'd0;
        endcase
        return {o[31], v, (o == 32'd0), o};
    endfunction

    // WAIT_CYCLES = 1 instance
    logic req0 = 0, req1 = 0, done0, done1, busy, grant, res_neg, res_ovf, res_zero;
    logic alu_neg, alu_ovf, alu_zero;
    aluop_t op0 = ALU_SLL, op1 = ALU_SLL, alu_op;
    logic [31:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0, result, alu_a, alu_b, alu_out;
    assign {alu_neg, alu_ovf, alu_zero, alu_out} = alu_f(alu_op, alu_a, alu_b);

    alu_arbiter #(.WAIT_CYCLES(1)) u_dut1 (
        .CLK(CLK), .nRST(nRST), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .done0(done0), .done1(done1), .busy(busy),
        .grant(grant), .result(result), .res_neg(res_neg), .res_ovf(res_ovf), .res_zero(res_zero),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
        .alu_neg(alu_neg), .alu_ovf(alu_ovf), .alu_zero(alu_zero)
    );

    // WAIT_CYCLES = 3 instance
    logic req0_3 = 0, req1_3 = 0, done0_3, done1_3, busy_3, grant_3, res_neg_3, res_ovf_3, res_zero_3;
    logic alu_neg_3, alu_ovf_3, alu_zero_3;
    aluop_t op0_3 = ALU_SLL, op1_3 = ALU_SLL, alu_op_3;
    logic [31:0] a0_3 = 0, b0_3 = 0, a1_3 = 0, b1_3 = 0, result_3, alu_a_3, alu_b_3, alu_out_3;
    assign {alu_neg_3, alu_ovf_3, alu_zero_3, alu_out_3} = alu_f(alu_op_3, alu_a_3, alu_b_3);

    alu_arbiter #(.WAIT_CYCLES(3)) u_dut3 (
        .CLK(CLK), .nRST(nRST), .req0(req0_3), .req1(req1_3), .op0(op0_3), .op1(op1_3),
        .a0(a0_3), .b0(b0_3), .a1(a1_3), .b1(b1_3), .done0(done0_3), .done1(done1_3), .busy(busy_3),
        .grant(grant_3), .result(result_3), .res_neg(res_neg_3), .res_ovf(res_ovf_3), .res_zero(res_zero_3),
        .alu_op(alu_op_3), .alu_a(alu_a_3), .alu_b(alu_b_3), .alu_out(alu_out_3),
        .alu_neg(alu_neg_3), .alu_ovf(alu_ovf_3), .alu_zero(alu_zero_3)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
    endtask

    task automatic test_reset;
        tick();
        checks++; if ({done0, done1, busy, grant} !== 4'b0000) begin failures++; $display("FAIL reset_ctrl got=%b exp=0000", {done0, done1, busy, grant}); end
        checks++; if ({result, res_neg, res_ovf, res_zero} !== 35'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", {result, res_neg, res_ovf, res_zero}); end
        checks++; if ({alu_op, alu_a, alu_b} !== 68'd0) begin failures++; $display("FAIL reset_alu got=%h exp=0", {alu_op, alu_a, alu_b}); end
        checks++; if ({done0_3, done1_3, busy_3, grant_3, alu_a_3} !== 36'd0) begin failures++; $display("FAIL reset_dut3 got=%h exp=0", {done0_3, done1_3, busy_3, grant_3, alu_a_3}); end
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_single_add;
        req0 = 1; op0 = ALU_ADD; a0 = 32'd10; b0 = 32'd10;
        tick();
        checks++; if ({busy, grant, done0, done1} !== 4'b1000) begin failures++; $display("FAIL add_exec_ctrl got=%b exp=1000", {busy, grant, done0, done1}); end
        checks++; if ({alu_op, alu_a, alu_b} !== {ALU_ADD, 32'd10, 32'd10}) begin failures++; $display("FAIL add_alu_drive got=%h exp=%h", {alu_op, alu_a, alu_b}, {ALU_ADD, 32'd10, 32'd10}); end
        tick();
        checks++; if ({done1, done0} !== 2'b01) begin failures++; $display("FAIL add_done got=%b exp=01", {done1, done0}); end
        checks++; if (result !== 32'd20) begin failures++; $display("FAIL add_result got=%h exp=%h", result, 32'd20); end
        checks++; if ({res_neg, res_ovf, res_zero} !== 3'b000) begin failures++; $display("FAIL add_flags got=%b exp=000", {res_neg, res_ovf, res_zero}); end
        req0 = 0;
        tick();
        checks++; if ({busy, done0, done1} !== 3'b000 || result !== 32'd20) begin failures++; $display("FAIL add_idle got=%b/%h exp=000/14", {busy, done0, done1}, result); end
    endtask

    task automatic test_tie;
        logic [31:0] exp_res;
        logic [2:0]  exp_flags;
        do_reset();
        req0 = 1; op0 = ALU_SUB; a0 = 32'd10; b0 = 32'd15;
        req1 = 1; op1 = ALU_ADD; a1 = 32'hFFFF_FFF6; b1 = 32'd10;
        for (int t = 0; t < 4; t++) begin
            exp_res   = t[0] ? 32'd0 : 32'hFFFF_FFFB;
            exp_flags = t[0] ? 3'b001 : 3'b100;
            tick();
            checks++; if ({busy, grant} !== {1'b1, t[0]}) begin failures++; $display("FAIL tie_grant%0d got=%b exp=%b", t, {busy, grant}, {1'b1, t[0]}); end
            tick();
            checks++; if ({done1, done0} !== (t[0] ? 2'b10 : 2'b01)) begin failures++; $display("FAIL tie_done%0d got=%b exp=%b", t, {done1, done0}, t[0] ? 2'b10 : 2'b01); end
            checks++; if ({result, res_neg, res_ovf, res_zero} !== {exp_res, exp_flags}) begin failures++; $display("FAIL tie_result%0d got=%h/%b exp=%h/%b", t, result, {res_neg, res_ovf, res_zero}, exp_res, exp_flags); end
            if (t == 3) begin req0 = 0; req1 = 0; end
            tick();
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL tie_idle%0d got=%b exp=0", t, busy); end
        end
    endtask

    task automatic test_overflow;
        req1 = 1; op1 = ALU_ADD; a1 = 32'h7FFF_FFFF; b1 = 32'h0000_0001;
        tick();
        checks++; if ({busy, grant} !== 2'b11) begin failures++; $display("FAIL ovf_grant got=%b exp=11", {busy, grant}); end
        tick();
        checks++; if ({done1, done0} !== 2'b10) begin failures++; $display("FAIL ovf_done got=%b exp=10", {done1, done0}); end
        checks++; if ({result, res_neg, res_ovf, res_zero} !== {32'h8000_0000, 3'b110}) begin failures++; $display("FAIL ovf_result got=%h/%b exp=80000000/110", result, {res_neg, res_ovf, res_zero}); end
        req1 = 0;
        tick();
    endtask

    task automatic test_reset_mid;
        req0 = 1; op0 = ALU_AND; a0 = 32'hABAB_ABAB; b0 = 32'hBABA_BABA;
        tick();
        checks++; if ({busy, alu_a} !== {1'b1, 32'hABAB_ABAB}) begin failures++; $display("FAIL rmid_exec got=%h exp=1abababab", {busy, alu_a}); end
        #2 nRST = 1'b0;
        #1;
        checks++; if ({done0, done1, busy, grant, res_neg, res_ovf, res_zero} !== 7'd0) begin failures++; $display("FAIL rmid_ctrl got=%b exp=0000000", {done0, done1, busy, grant, res_neg, res_ovf, res_zero}); end
        checks++; if ({result, alu_op, alu_a, alu_b} !== 100'd0) begin failures++; $display("FAIL rmid_data got=%h exp=0", {result, alu_op, alu_a, alu_b}); end
        tick();
        checks++; if ({done0, done1, busy} !== 3'b000) begin failures++; $display("FAIL rmid_nodone got=%b exp=000", {done0, done1, busy}); end
        nRST = 1'b1;
        tick();
        checks++; if ({busy, grant, alu_a, alu_b} !== {2'b10, 32'hABAB_ABAB, 32'hBABA_BABA}) begin failures++; $display("FAIL rmid_restart got=%h", {busy, grant, alu_a, alu_b}); end
        tick();
        checks++; if ({done1, done0, result, res_neg, res_ovf, res_zero} !== {2'b01, 32'hAAAA_AAAA, 3'b100}) begin failures++; $display("FAIL rmid_result got=%b/%h exp=01/aaaaaaaa", {done1, done0}, result); end
        req0 = 0;
        tick();
    endtask

    task automatic test_back_to_back;
        req0 = 1; op0 = ALU_ADD; a0 = 32'd1; b0 = 32'd2;
        for (int i = 1; i <= 9; i++) begin
            tick();
            checks++; if ({done1, done0} !== ((i % 3 == 2) ? 2'b01 : 2'b00)) begin failures++; $display("FAIL b2b_done%0d got=%b exp=%b", i, {done1, done0}, (i % 3 == 2) ? 2'b01 : 2'b00); end
            if (i == 8) req0 = 0;
        end
        checks++; if ({busy, result} !== {1'b0, 32'd3}) begin failures++; $display("FAIL b2b_end got=%h exp=000000003", {busy, result}); end
    endtask

    task automatic test_wait3;
        req0_3 = 1; op0_3 = ALU_SLL; a0_3 = 32'd1; b0_3 = 32'd5;
        tick();
        checks++; if ({busy_3, alu_a_3, alu_b_3} !== {1'b1, 32'd1, 32'd5}) begin failures++; $display("FAIL w3_drive got=%h", {busy_3, alu_a_3, alu_b_3}); end
        a0_3 = 32'h0000_FFFF; b0_3 = 32'd3;
        for (int i = 2; i <= 3; i++) begin
            tick();
            checks++; if ({done0_3, done1_3, alu_a_3, alu_b_3} !== {2'b00, 32'd1, 32'd5}) begin failures++; $display("FAIL w3_hold%0d got=%h", i, {done0_3, done1_3, alu_a_3, alu_b_3}); end
        end
        tick();
        checks++; if ({done1_3, done0_3} !== 2'b01) begin failures++; $display("FAIL w3_done got=%b exp=01", {done1_3, done0_3}); end
        checks++; if ({result_3, alu_a_3} !== {32'h0000_0020, 32'd1}) begin failures++; $display("FAIL w3_result got=%h exp=0000002000000001", {result_3, alu_a_3}); end
        req0_3 = 0;
        tick();
        checks++; if ({busy_3, done0_3} !== 2'b00) begin failures++; $display("FAIL w3_idle got=%b exp=00", {busy_3, done0_3}); end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_tie();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        test_wait3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
